// File: rtl/reg_lock_scoreboard_pkg.sv
// reg_lock_scoreboard_pkg: shared sizes, types and FSM states for the register-lock scoreboard
package reg_lock_scoreboard_pkg;
  localparam int NUM_REGS = 32;
  localparam int NUM_OUTSTANDING = 4;
  localparam int MAX_OUTSTANDING = NUM_OUTSTANDING;
  typedef logic [NUM_REGS-1:0] locks_t;
  typedef logic [$clog2(NUM_REGS)-1:0] reg_idx_t;
  typedef logic [$clog2(NUM_OUTSTANDING+1)-1:0] lock_cnt_t;
  typedef enum logic {IDLE, BLOCK_WAIT} state_e;
endpackage

// File: rtl/reg_lock_scoreboard_if.sv
// reg_lock_scoreboard_if: launch/writeback/lock bundle between launcher, commit path and scoreboard
interface reg_lock_scoreboard_if #(
  parameter int NUM_REGS = reg_lock_scoreboard_pkg::NUM_REGS,
  parameter int MAX_OUTSTANDING = reg_lock_scoreboard_pkg::MAX_OUTSTANDING
) ();
  logic launch_valid_i;
  logic launch_ready_o;
  logic [$clog2(NUM_REGS)-1:0] launch_rd_i;
  logic launch_blocking_i;
  logic wb_valid_i;
  logic [$clog2(NUM_REGS)-1:0] wb_rd_i;
  logic wb_blocking_i;
  logic [NUM_REGS-1:0] locks_o;
  logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o;
  logic blocking_active_o;
`ifdef REG_LOCK_SCOREBOARD_ERR_EN
  logic err_o;
  modport slave (
    input launch_valid_i, launch_rd_i, launch_blocking_i, wb_valid_i, wb_rd_i, wb_blocking_i,
    output launch_ready_o, locks_o, outstanding_o, blocking_active_o, err_o
  );
  modport master (
    output launch_valid_i, launch_rd_i, launch_blocking_i, wb_valid_i, wb_rd_i, wb_blocking_i,
    input launch_ready_o, locks_o, outstanding_o, blocking_active_o, err_o
  );
`else
  modport slave (
    input launch_valid_i, launch_rd_i, launch_blocking_i, wb_valid_i, wb_rd_i, wb_blocking_i,
    output launch_ready_o, locks_o, outstanding_o, blocking_active_o
  );
  modport master (
    output launch_valid_i, launch_rd_i, launch_blocking_i, wb_valid_i, wb_rd_i, wb_blocking_i,
    input launch_ready_o, locks_o, outstanding_o, blocking_active_o
  );
`endif
endinterface

// File: rtl/reg_lock_scoreboard_lock_counter.sv
// lock_counter: saturating up/down counter; simultaneous inc and dec cancel out
module lock_counter #(
  parameter int MAX = 4,
  parameter int W = $clog2(MAX + 1)
) (
  input  logic         clk_i,
  input  logic         arst_ni,
  input  logic         clear_i,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         nonzero_o,
  output logic         full_o
);
  logic [W-1:0] cnt_q, cnt_d;
  assign nonzero_o = cnt_q != '0;
  assign full_o = cnt_q == W'(MAX);
  assign cnt_o = cnt_q;
  always_comb
    cnt_d = clear_i ? '0 :
            (inc_i & ~dec_i & ~full_o) ? cnt_q + 1'b1 :
            (dec_i & ~inc_i & nonzero_o) ? cnt_q - 1'b1 : cnt_q;
  always_ff @(posedge clk_i or negedge arst_ni)
    if (!arst_ni) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/reg_lock_scoreboard.sv
// reg_lock_scoreboard: per-register lock vector for the launcher; all regs lock while a blocking op is in flight
// Optional sticky protocol-error output err_o when REG_LOCK_SCOREBOARD_ERR_EN is defined.
module reg_lock_scoreboard #(
  parameter int NUM_REGS = reg_lock_scoreboard_pkg::NUM_REGS,
  parameter int MAX_OUTSTANDING = reg_lock_scoreboard_pkg::MAX_OUTSTANDING
) (
  input logic clk_i,
  input logic arst_ni,
  input logic clear_i,
  reg_lock_scoreboard_if.slave bus
);
  import reg_lock_scoreboard_pkg::*;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int RW = $clog2(NUM_REGS);
  state_e state_q, state_d;
  logic active_q, active_d;
  logic [NUM_REGS-1:0] reg_nz, reg_full;
  logic [CW-1:0] tot_cnt;
  logic tot_nz, tot_full, idle, ready, fire, nb_fire, wb_nb, wb_blk;
  always_comb begin
    idle = state_q == IDLE;
    ready = active_q & idle & ~tot_full &
            (bus.launch_blocking_i ? ~tot_nz : ~reg_full[bus.launch_rd_i]);
    fire = bus.launch_valid_i & ready;
    nb_fire = fire & ~bus.launch_blocking_i;
    wb_nb = bus.wb_valid_i & ~bus.wb_blocking_i & idle;
    wb_blk = bus.wb_valid_i & bus.wb_blocking_i & ~idle;
    state_d = clear_i ? IDLE :
              (fire & bus.launch_blocking_i) ? BLOCK_WAIT :
              wb_blk ? IDLE : state_q;
    active_d = 1'b1;
  end
  always_ff @(posedge clk_i or negedge arst_ni)
    if (!arst_ni) begin
      state_q <= IDLE;
      active_q <= 1'b0;
    end else begin
      state_q <= state_d;
      active_q <= active_d;
    end
  // r0 has no counter: it never locks and never limits a launch
  assign reg_nz[0] = 1'b0;
  assign reg_full[0] = 1'b0;
  for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
    logic [CW-1:0] unused_cnt;
    lock_counter #(.MAX(MAX_OUTSTANDING), .W(CW)) u_cnt (
      .clk_i(clk_i),
      .arst_ni(arst_ni),
      .clear_i(clear_i),
      .inc_i(nb_fire && bus.launch_rd_i == RW'(r)),
      .dec_i(wb_nb && bus.wb_rd_i == RW'(r)),
      .cnt_o(unused_cnt),
      .nonzero_o(reg_nz[r]),
      .full_o(reg_full[r])
    );
  end
  lock_counter #(.MAX(MAX_OUTSTANDING), .W(CW)) u_total (
    .clk_i(clk_i),
    .arst_ni(arst_ni),
    .clear_i(clear_i),
    .inc_i(fire),
    .dec_i(wb_nb | wb_blk),
    .cnt_o(tot_cnt),
    .nonzero_o(tot_nz),
    .full_o(tot_full)
  );
  assign bus.launch_ready_o = ready;
  assign bus.blocking_active_o = ~idle;
  assign bus.outstanding_o = tot_cnt;
  assign bus.locks_o = {reg_nz[NUM_REGS-1:1] | {(NUM_REGS-1){~idle}}, 1'b0};
`ifdef REG_LOCK_SCOREBOARD_ERR_EN
  logic err_q, err_d, pend_q, pend_d;
  // a refused launch is only an error once the launcher withdraws it
  always_comb begin
    pend_d = ~clear_i & bus.launch_valid_i & ~ready;
    err_d = ~clear_i & (err_q |
            (wb_nb & ((bus.wb_rd_i != '0 && !reg_nz[bus.wb_rd_i]) | ~tot_nz)) |
            (bus.wb_valid_i & ~(bus.wb_blocking_i ^ idle)) |
            (pend_q & ~bus.launch_valid_i));
  end
  always_ff @(posedge clk_i or negedge arst_ni)
    if (!arst_ni) begin
      err_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      err_q <= err_d;
      pend_q <= pend_d;
    end
  assign bus.err_o = err_q;
`endif
endmodule

// File: tb/tb_reg_lock_scoreboard.sv
// tb_reg_lock_scoreboard: directed and random traffic against a queued reference model of the scoreboard
module tb_reg_lock_scoreboard;
  localparam int NR = 32;
  localparam int MO = 4;
  typedef struct packed {
    logic [31:0] locks;
    logic [2:0] outs;
    logic blk;
  } exp_t;
  logic clk_i = 1'b0;
  logic arst_ni = 1'b0;
  logic clear_i = 1'b0;
  always #5 clk_i = ~clk_i;
  reg_lock_scoreboard_if bus ();
  reg_lock_scoreboard dut (.clk_i(clk_i), .arst_ni(arst_ni), .clear_i(clear_i), .bus(bus));
  exp_t sb_q[$];
  int n_chk = 0;
  int n_bad = 0;
  int mcnt[NR];
  int mtot;
  bit mblk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic bit mready(input bit blk, input int rd);
    return !mblk && mtot < MO && (blk ? mtot == 0 : (rd == 0 || mcnt[rd] < MO));
  endfunction
  function automatic exp_t mexp();
    exp_t e;
    e.locks = '0;
    for (int r = 1; r < NR; r++) e.locks[r] = (mcnt[r] != 0) || mblk;
    e.outs = 3'(mtot);
    e.blk = mblk;
    return e;
  endfunction
  task automatic step(input bit lv, input int lrd, input bit lb, input bit wv, input int wrd,
                      input bit wb, input bit clr);
    bit fire, wbn, wbb;
    exp_t e;
    bus.launch_valid_i = lv;
    bus.launch_rd_i = 5'(lrd);
    bus.launch_blocking_i = lb;
    bus.wb_valid_i = wv;
    bus.wb_rd_i = 5'(wrd);
    bus.wb_blocking_i = wb;
    clear_i = clr;
    #1;
    chk("ready", 64'(bus.launch_ready_o), 64'(mready(lb, lrd)));
    fire = lv && mready(lb, lrd);
    if (clr) begin
      for (int r = 0; r < NR; r++) mcnt[r] = 0;
      mtot = 0;
      mblk = 0;
    end else begin
      wbn = wv && !wb && !mblk;
      wbb = wv && wb && mblk;
      for (int r = 1; r < NR; r++) begin
        bit i, d;
        i = fire && !lb && lrd == r;
        d = wbn && wrd == r;
        if (i && !d && mcnt[r] < MO) mcnt[r]++;
        else if (d && !i && mcnt[r] > 0) mcnt[r]--;
      end
      if (fire && !(wbn || wbb) && mtot < MO) mtot++;
      else if ((wbn || wbb) && !fire && mtot > 0) mtot--;
      if (fire && lb) mblk = 1;
      else if (wbb) mblk = 0;
    end
    sb_q.push_back(mexp());
    @(posedge clk_i);
    #1;
    if (sb_q.size() == 0) chk("sb_empty", 64'(1), 64'(0));
    else begin
      e = sb_q.pop_front();
      chk("locks", 64'(bus.locks_o), 64'(e.locks));
      chk("outstanding", 64'(bus.outstanding_o), 64'(e.outs));
      chk("blocking", 64'(bus.blocking_active_o), 64'(e.blk));
    end
  endtask
  initial begin
    bus.launch_valid_i = 1'b0;
    bus.launch_rd_i = '0;
    bus.launch_blocking_i = 1'b0;
    bus.wb_valid_i = 1'b0;
    bus.wb_rd_i = '0;
    bus.wb_blocking_i = 1'b0;
    for (int r = 0; r < NR; r++) mcnt[r] = 0;
    mtot = 0;
    mblk = 0;
    #100;
    chk("rst_locks", 64'(bus.locks_o), 64'(0));
    chk("rst_out", 64'(bus.outstanding_o), 64'(0));
    chk("rst_ready", 64'(bus.launch_ready_o), 64'(0));
    chk("rst_blk", 64'(bus.blocking_active_o), 64'(0));
    @(negedge clk_i);
    arst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    chk("rel_ready", 64'(bus.launch_ready_o), 64'(1));
    repeat (4) step(1, 5, 0, 0, 0, 0, 0);
    chk("q4_locks", 64'(bus.locks_o), 64'h20);
    chk("q4_out", 64'(bus.outstanding_o), 64'(4));
    chk("q4_ready", 64'(bus.launch_ready_o), 64'(0));
    step(0, 5, 0, 1, 5, 0, 0);
    chk("wb1_ready", 64'(bus.launch_ready_o), 64'(1));
    chk("wb1_locks", 64'(bus.locks_o), 64'h20);
    repeat (3) step(0, 5, 0, 1, 5, 0, 0);
    chk("drain_locks", 64'(bus.locks_o), 64'(0));
    step(1, 7, 0, 0, 0, 0, 0);
    step(1, 7, 0, 1, 7, 0, 0);
    chk("same_locks", 64'(bus.locks_o), 64'h80);
    chk("same_out", 64'(bus.outstanding_o), 64'(1));
    step(1, 9, 1, 0, 0, 0, 0);
    chk("blk_busy_ready", 64'(bus.launch_ready_o), 64'(0));
    step(0, 0, 0, 1, 7, 0, 0);
    step(1, 0, 1, 0, 0, 0, 0);
    chk("blk_locks", 64'(bus.locks_o), 64'hFFFF_FFFE);
    chk("blk_active", 64'(bus.blocking_active_o), 64'(1));
    chk("blk_ready", 64'(bus.launch_ready_o), 64'(0));
    step(0, 0, 0, 1, 3, 0, 0);
    chk("blk_nbwb_locks", 64'(bus.locks_o), 64'hFFFF_FFFE);
    step(0, 0, 0, 1, 0, 1, 0);
    chk("unblk_locks", 64'(bus.locks_o), 64'(0));
    chk("unblk_active", 64'(bus.blocking_active_o), 64'(0));
    chk("unblk_out", 64'(bus.outstanding_o), 64'(0));
    step(1, 0, 0, 0, 0, 0, 0);
    chk("r0_locks", 64'(bus.locks_o), 64'(0));
    chk("r0_out", 64'(bus.outstanding_o), 64'(1));
    step(0, 0, 0, 1, 3, 0, 0);
    chk("under_locks", 64'(bus.locks_o), 64'(0));
    step(1, 1, 0, 0, 0, 0, 0);
    step(1, 2, 0, 0, 0, 0, 0);
    step(1, 3, 0, 0, 0, 0, 0);
    chk("pre_clr_out", 64'(bus.outstanding_o), 64'(3));
    step(1, 4, 0, 0, 0, 0, 1);
    chk("clr_locks", 64'(bus.locks_o), 64'(0));
    chk("clr_out", 64'(bus.outstanding_o), 64'(0));
    chk("clr_blk", 64'(bus.blocking_active_o), 64'(0));
    for (int k = 0; k < 15000; k++)
      step($urandom_range(0, 1) == 1, int'($urandom_range(0, 7)), $urandom_range(0, 15) == 0,
           $urandom_range(0, 1) == 1, int'($urandom_range(0, 7)),
           mblk ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 15) == 0),
           $urandom_range(0, 63) == 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/reg_lock_scoreboard.md
Name: reg_lock_scoreboard

Overview:
- Producer of the register-lock vector that the instruction launcher consumes as its locks input.
- Tracks destination registers of launched, not-yet-written-back instructions.
- Locks all registers while a blocking instruction is in flight.
- Sits between the launcher output handshake and the writeback/commit path. Its lock outputs close the launch/retire loop.

Parameters:
- NUM_REGS, 32, number of architectural registers; register 0 is never locked.
- MAX_OUTSTANDING, 4, maximum in-flight instructions (per register and total).

Ports:
- clk_i  input  1  clock, rising edge.
- arst_ni  input  1  asynchronous active-low reset.
- clear_i  input  1  synchronous flush; drops all tracking.
- launch_valid_i  input  1  launcher has an instruction leaving (instr_out valid & ready).
- launch_ready_o  output  1  scoreboard can record the launch.
- launch_rd_i  input  $clog2(NUM_REGS)  destination register of the launch.
- launch_blocking_i  input  1  launched instruction is blocking.
- wb_valid_i  input  1  writeback of one in-flight instruction this cycle.
- wb_rd_i  input  $clog2(NUM_REGS)  writeback destination register.
- wb_blocking_i  input  1  writeback belongs to the blocking instruction.
- locks_o  output  NUM_REGS  per-register lock vector to the launcher.
- outstanding_o  output  $clog2(MAX_OUTSTANDING+1)  total in-flight count.
- blocking_active_o  output  1  FSM is in BLOCK_WAIT.

Behaviour:
- Reset (arst_ni=0, asynchronous) and clear_i=1 at a rising edge have the same effect:
  - all per-register counters = 0, total = 0, FSM = IDLE;
  - locks_o = 0, outstanding_o = 0, blocking_active_o = 0.
  - launch_ready_o = 0 while arst_ni=0; launch_ready_o = 1 after reset releases.
- clear_i has priority over a simultaneous launch or writeback; both are discarded.
- Per-register counter cnt[r], 0..MAX_OUTSTANDING, saturating.
- locks_o[r] = (cnt[r] != 0) | blocking_active, for r != 0. locks_o[0] = 0 always.
- Outputs are derived from registered state only. A launch accepted at edge N shows its lock from edge N onward (visible in the next cycle). A writeback at edge M clears from edge M onward. There is no combinational path from launch or wb inputs to locks_o.
- Non-blocking launch, accepted when launch_valid_i & launch_ready_o:
  - cnt[rd] += 1 if rd != 0;
  - total += 1 always (rd=0 still occupies an outstanding slot).
- Non-blocking writeback (wb_valid_i & ~wb_blocking_i):
  - cnt[wb_rd] -= 1 if wb_rd != 0 and cnt != 0;
  - total -= 1 if total != 0.
- Same-cycle launch and writeback:
  - same rd: cnt unchanged and total unchanged;
  - different rd: each counter updates independently, total unchanged.
- Underflow (writeback to a zero counter, or total=0) is ignored; no wrap.
- launch_ready_o = 1 when all of the following hold:
  - state == IDLE;
  - total < MAX_OUTSTANDING;
  - for a non-blocking launch: cnt[launch_rd_i] < MAX_OUTSTANDING;
  - for a blocking launch: total == 0.
  - launch_ready_o may depend combinationally on launch_rd_i and launch_blocking_i.
- FSM:
  - IDLE -> BLOCK_WAIT on an accepted blocking launch. Total becomes 1; per-register counters are untouched.
  - BLOCK_WAIT: locks_o = all ones except bit 0. launch_ready_o = 0. Non-blocking writebacks are ignored.
  - BLOCK_WAIT -> IDLE on wb_valid_i & wb_blocking_i. Total becomes 0, and locks_o reflects the counters (all zero) from the next cycle.
  - wb_blocking_i while in IDLE: ignored.

Optional Feature:
- Macro: REG_LOCK_SCOREBOARD_ERR_EN.
- When defined, adds output err_o (1 bit), sticky until reset or clear_i. It sets on any of:
  - a writeback that underflows;
  - wb_blocking_i in IDLE;
  - a non-blocking writeback in BLOCK_WAIT;
  - launch_valid_i & ~launch_ready_o held high while the launcher expects acceptance. In this case err_o is set only when launch_valid_i drops without a handshake.
- When undefined: no err_o port; the error conditions are silently ignored as described above.

Decomposition:
- maverickOne_pkg supplies NUM_REGS and NUM_OUTSTANDING; MAX_OUTSTANDING defaults to NUM_OUTSTANDING in the package.
- Add to the package:
  - locks_t = logic [NUM_REGS-1:0];
  - reg_idx_t = logic [$clog2(NUM_REGS)-1:0];
  - lock_cnt_t = logic [$clog2(NUM_OUTSTANDING+1)-1:0].
- One sub-module: lock_counter.
  - A saturating up/down counter with inc/dec/clear inputs and nonzero/full outputs.
  - Instantiated NUM_REGS-1 times for the registers, and once more for the total.

Test Plan:
- Reset: hold arst_ni=0 for 100ns -> locks_o=0, outstanding_o=0, launch_ready_o=0; release -> launch_ready_o=1.
- Launch rd=5 ×4, no wb -> cnt[5]=4, locks_o=0x20, outstanding_o=4, launch_ready_o=0. Then wb rd=5 once -> ready=1, locks_o still 0x20. After 4 wbs -> locks_o=0.
- Same-cycle launch rd=7 and wb rd=7 with cnt[7]=1 -> cnt[7] stays 1, locks_o[7]=1, outstanding_o unchanged.
- Blocking launch with total=1 -> launch_ready_o=0. Drain to 0, then launch blocking -> locks_o=0xFFFF_FFFE, blocking_active_o=1. Then wb_blocking_i -> locks_o=0, blocking_active_o=0 next cycle.
- Launch rd=0 -> locks_o=0, outstanding_o=1. Wb rd=3 with cnt[3]=0 -> no change (err_o=1 when REG_LOCK_SCOREBOARD_ERR_EN is defined).
- clear_i=1 with 3 in-flight and a simultaneous launch -> next cycle locks_o=0, outstanding_o=0, FSM=IDLE. Random launch/wb/clear traffic run for 15000 cycles against a reference-model comparison of locks_o.
